uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundles the four-requester arbiter handshake and the UART transmitter side.
// Latency: none, this file only declares wires.
// Backpressure: requests stay pending while req stays high; ack/done are the completion pulses.
interface uart_tx_arbiter_if #(
    parameter int DBITS = 8
);
    logic [3:0]         req;
    logic [4*DBITS-1:0] data_in;
    logic [3:0]         ack;
    logic [3:0]         done;
    logic               tx_start;
    logic [DBITS-1:0]   tx_din;
    logic               tx_done;
    logic               busy;
    logic [1:0]         owner;
    logic               timeout_err;

    // Requester / transmitter side.
    modport master (
        output req, data_in, tx_done,
        input  ack, done, tx_start, tx_din, busy, owner, timeout_err
    );

    // Arbiter side.
    modport slave (
        input  req, data_in, tx_done,
        output ack, done, tx_start, tx_din, busy, owner, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one UART transmitter among four requesters.
// Latency: ack/tx_start one cycle after the grant edge; done one cycle after tx_done.
// Backpressure: one transfer at a time; a request stays pending while req is held, and the transfer is aborted after TIMEOUT cycles without tx_done.
module uart_tx_arbiter #(
    parameter int DBITS   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_ptr;
    logic [15:0]      r_cnt;
    logic [1:0]       r_owner;
    logic [DBITS-1:0] r_tx_din;
    logic             r_tx_start;
    logic [3:0]       r_ack;
    logic [3:0]       r_done;
    logic             r_busy;
    logic             r_timeout_err;

    logic             w_win_vld;
    logic [1:0]       w_win_idx;
    logic [1:0]       w_cand;

    // Pick the first requester after the last-served one; walk backwards so the
    // nearest candidate (ptr+1) overwrites the farther ones.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'd0;
        w_cand    = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (bus.req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    // Main FSM; pulses default low each cycle so they last exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 2'd3;
            r_cnt         <= 16'd0;
            r_owner       <= 2'd0;
            r_tx_din      <= '0;
            r_tx_start    <= 1'b0;
            r_ack         <= 4'd0;
            r_done        <= 4'd0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_start    <= 1'b0;
            r_ack         <= 4'd0;
            r_done        <= 4'd0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_state    <= ST_START;
                        r_owner    <= w_win_idx;
                        r_tx_din   <= bus.data_in[w_win_idx*DBITS +: DBITS];
                        r_tx_start <= 1'b1;
                        r_ack      <= 4'b0001 << w_win_idx;
                        r_busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    // tx_done is deliberately not looked at here.
                    r_state <= ST_WAIT;
                    r_cnt   <= 16'd0;
                end
                ST_WAIT: begin
                    if (bus.tx_done) begin
                        r_state <= ST_DONE;
                        r_done  <= 4'b0001 << r_owner;
                        r_ptr   <= r_owner;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= ST_IDLE;
                        r_timeout_err <= 1'b1;
                        r_ptr         <= r_owner;
                        r_busy        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_start    = r_tx_start;
    assign bus.tx_din      = r_tx_din;
    assign bus.ack         = r_ack;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.owner       = r_owner;
    assign bus.timeout_err = r_timeout_err;
endmodule
